// File: rtl/ex_operand_stage_pkg.sv
// Shared constants for the E-stage operand register and forwarding network.
package ex_operand_stage_pkg;

   // Width of the Tnew countdown field
   localparam int unsigned TNEW_W = 2;

   // ALU opcode encodings carried from D to E
   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_SLT   = 4'd4;
   localparam logic [3:0] ALU_SLTU  = 4'd5;
   localparam logic [3:0] ALU_PASSB = 4'd6;

   // Field values of a bubble (identical to the reset state)
   localparam logic [3:0]        NOP_ALUOP = ALU_ADD;
   localparam logic [TNEW_W-1:0] NOP_TNEW  = 2'd0;
   localparam logic              NOP_VALID = 1'b0;
   localparam logic              NOP_BSEL  = 1'b0;

   // One pipeline stage of Tnew progress, saturating at zero
   function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
      logic [TNEW_W-1:0] r;
      if (t == 2'd0) begin
         r = 2'd0;
      end else begin
         r = t - 2'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Priority forwarding select for one E-stage source operand:
// register 0 reads as zero, then M (if its result is ready), then W, then
// the value captured in the D/E register.
module ex_operand_stage_fwd_mux #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic [RW-1:0] addr_i,
   input  logic [DW-1:0] val_i,
   input  logic [RW-1:0] m_wa_i,
   input  logic [DW-1:0] m_wd_i,
   input  logic          m_ready_i,
   input  logic [RW-1:0] w_wa_i,
   input  logic [DW-1:0] w_wd_i,
   input  logic          w_we_i,
   output logic [DW-1:0] fwd_o
);

   // Select the youngest valid producer of this register
   always_comb begin
      fwd_o = val_i;
      if (addr_i == {RW{1'b0}}) begin
         fwd_o = {DW{1'b0}};
      end else if ((addr_i == m_wa_i) && m_ready_i) begin
         fwd_o = m_wd_i;
      end else if ((addr_i == w_wa_i) && w_we_i) begin
         fwd_o = w_wd_i;
      end else begin
         fwd_o = val_i;
      end
   end

endmodule

// File: rtl/ex_operand_stage.sv
// D/E pipeline register plus E-stage operand forwarding. Captures decoded
// operands each cycle, inserts bubbles on stall/flush, freezes on e_hold
// while refreshing stored source values so drained M/W data is kept.
module ex_operand_stage
   import ex_operand_stage_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              e_hold,
   input  logic              d_valid,
   input  logic [DW-1:0]     d_pc,
   input  logic [RW-1:0]     d_rs_addr,
   input  logic [RW-1:0]     d_rt_addr,
   input  logic [DW-1:0]     d_rs_val,
   input  logic [DW-1:0]     d_rt_val,
   input  logic [DW-1:0]     d_imm,
   input  logic              d_bsel,
   input  logic [3:0]        d_aluop,
   input  logic [RW-1:0]     d_wa,
   input  logic [TNEW_W-1:0] d_tnew,
   input  logic [RW-1:0]     m_wa,
   input  logic [RW-1:0]     w_wa,
   input  logic [DW-1:0]     m_wd,
   input  logic [DW-1:0]     w_wd,
   input  logic              m_ready,
   input  logic              w_we,
   output logic [DW-1:0]     e_sa,
   output logic [DW-1:0]     e_sb,
   output logic [DW-1:0]     e_rt_fwd,
   output logic [3:0]        e_aluop,
   output logic [DW-1:0]     e_pc,
   output logic [RW-1:0]     e_wa,
   output logic [TNEW_W-1:0] e_tnew,
   output logic              e_valid
);

   logic [DW-1:0]     pc_q,      pc_d;
   logic [RW-1:0]     rs_addr_q, rs_addr_d;
   logic [RW-1:0]     rt_addr_q, rt_addr_d;
   logic [DW-1:0]     rs_val_q,  rs_val_d;
   logic [DW-1:0]     rt_val_q,  rt_val_d;
   logic [DW-1:0]     imm_q,     imm_d;
   logic              bsel_q,    bsel_d;
   logic [3:0]        aluop_q,   aluop_d;
   logic [RW-1:0]     wa_q,      wa_d;
   logic [TNEW_W-1:0] tnew_q,    tnew_d;
   logic              valid_q,   valid_d;

   logic [DW-1:0]     rs_fwd_s;
   logic [DW-1:0]     rt_fwd_s;

   ex_operand_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
      .addr_i    (rs_addr_q),
      .val_i     (rs_val_q),
      .m_wa_i    (m_wa),
      .m_wd_i    (m_wd),
      .m_ready_i (m_ready),
      .w_wa_i    (w_wa),
      .w_wd_i    (w_wd),
      .w_we_i    (w_we),
      .fwd_o     (rs_fwd_s)
   );

   ex_operand_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
      .addr_i    (rt_addr_q),
      .val_i     (rt_val_q),
      .m_wa_i    (m_wa),
      .m_wd_i    (m_wd),
      .m_ready_i (m_ready),
      .w_wa_i    (w_wa),
      .w_wd_i    (w_wd),
      .w_we_i    (w_we),
      .fwd_o     (rt_fwd_s)
   );

   // Next-state selection: hold (with operand refresh) beats bubble beats load
   always_comb begin
      pc_d      = pc_q;
      rs_addr_d = rs_addr_q;
      rt_addr_d = rt_addr_q;
      rs_val_d  = rs_val_q;
      rt_val_d  = rt_val_q;
      imm_d     = imm_q;
      bsel_d    = bsel_q;
      aluop_d   = aluop_q;
      wa_d      = wa_q;
      tnew_d    = tnew_q;
      valid_d   = valid_q;
      if (e_hold) begin
         // Keep the instruction, but latch whatever M/W supply right now
         rs_val_d = rs_fwd_s;
         rt_val_d = rt_fwd_s;
      end else if (flush || stall) begin
         pc_d      = {DW{1'b0}};
         rs_addr_d = {RW{1'b0}};
         rt_addr_d = {RW{1'b0}};
         rs_val_d  = {DW{1'b0}};
         rt_val_d  = {DW{1'b0}};
         imm_d     = {DW{1'b0}};
         bsel_d    = NOP_BSEL;
         aluop_d   = NOP_ALUOP;
         wa_d      = {RW{1'b0}};
         tnew_d    = NOP_TNEW;
         valid_d   = NOP_VALID;
      end else begin
         pc_d      = d_pc;
         rs_addr_d = d_rs_addr;
         rt_addr_d = d_rt_addr;
         rs_val_d  = d_rs_val;
         rt_val_d  = d_rt_val;
         imm_d     = d_imm;
         bsel_d    = d_bsel;
         aluop_d   = d_aluop;
         wa_d      = d_valid ? d_wa : {RW{1'b0}};
         tnew_d    = tnew_dec(d_tnew);
         valid_d   = d_valid;
      end
   end

   // D/E register with synchronous active-low reset to the bubble state
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q      <= {DW{1'b0}};
         rs_addr_q <= {RW{1'b0}};
         rt_addr_q <= {RW{1'b0}};
         rs_val_q  <= {DW{1'b0}};
         rt_val_q  <= {DW{1'b0}};
         imm_q     <= {DW{1'b0}};
         bsel_q    <= NOP_BSEL;
         aluop_q   <= NOP_ALUOP;
         wa_q      <= {RW{1'b0}};
         tnew_q    <= NOP_TNEW;
         valid_q   <= NOP_VALID;
      end else begin
         pc_q      <= pc_d;
         rs_addr_q <= rs_addr_d;
         rt_addr_q <= rt_addr_d;
         rs_val_q  <= rs_val_d;
         rt_val_q  <= rt_val_d;
         imm_q     <= imm_d;
         bsel_q    <= bsel_d;
         aluop_q   <= aluop_d;
         wa_q      <= wa_d;
         tnew_q    <= tnew_d;
         valid_q   <= valid_d;
      end
   end

   assign e_sa     = rs_fwd_s;
   assign e_rt_fwd = rt_fwd_s;
   assign e_sb     = bsel_q ? imm_q : rt_fwd_s;
   assign e_aluop  = aluop_q;
   assign e_pc     = pc_q;
   assign e_wa     = wa_q;
   assign e_tnew   = tnew_q;
   assign e_valid  = valid_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: forwarding vector table,
// hand-written bubble/hold/Tnew/reset sequences, and random traffic against
// a reference model of the E-stage instruction slot.
module tb_ex_operand_stage;

   logic        clk = 1'b0;
   logic        reset, stall, flush, e_hold, d_valid, d_bsel, m_ready, w_we;
   logic [31:0] d_pc, d_rs_val, d_rt_val, d_imm, m_wd, w_wd;
   logic [4:0]  d_rs_addr, d_rt_addr, d_wa, m_wa, w_wa;
   logic [3:0]  d_aluop;
   logic [1:0]  d_tnew;
   logic [31:0] e_sa, e_sb, e_rt_fwd, e_pc;
   logic [3:0]  e_aluop;
   logic [4:0]  e_wa;
   logic [1:0]  e_tnew;
   logic        e_valid;

   int checks = 0;
   int failures = 0;

   ex_operand_stage #(.DW(32), .RW(5)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .e_hold(e_hold),
      .d_valid(d_valid), .d_pc(d_pc), .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
      .d_rs_val(d_rs_val), .d_rt_val(d_rt_val), .d_imm(d_imm), .d_bsel(d_bsel),
      .d_aluop(d_aluop), .d_wa(d_wa), .d_tnew(d_tnew),
      .m_wa(m_wa), .w_wa(w_wa), .m_wd(m_wd), .w_wd(w_wd),
      .m_ready(m_ready), .w_we(w_we),
      .e_sa(e_sa), .e_sb(e_sb), .e_rt_fwd(e_rt_fwd), .e_aluop(e_aluop),
      .e_pc(e_pc), .e_wa(e_wa), .e_tnew(e_tnew), .e_valid(e_valid)
   );

   always #5 clk = ~clk;

   // Reference model: the instruction currently sitting in E
   logic        md_valid, md_bsel;
   logic [31:0] md_pc, md_rs_v, md_rt_v, md_imm;
   logic [4:0]  md_rs_a, md_rt_a, md_wa;
   logic [3:0]  md_op;
   logic [1:0]  md_tnew;

   function automatic logic [31:0] fwd_ref(input logic [4:0] a, input logic [31:0] v);
      if (a == 5'd0)                 return 32'd0;
      if (a == m_wa && m_ready)      return m_wd;
      if (a == w_wa && w_we)         return w_wd;
      return v;
   endfunction

   task automatic model_clear();
      md_valid = 1'b0; md_bsel = 1'b0; md_pc = 32'd0; md_rs_v = 32'd0;
      md_rt_v = 32'd0; md_imm = 32'd0; md_rs_a = 5'd0; md_rt_a = 5'd0;
      md_wa = 5'd0; md_op = 4'd0; md_tnew = 2'd0;
   endtask

   // What the E slot becomes at the coming edge, given the present inputs
   task automatic model_edge();
      logic [31:0] ra, rb;
      ra = fwd_ref(md_rs_a, md_rs_v);
      rb = fwd_ref(md_rt_a, md_rt_v);
      if (!reset) begin
         model_clear();
      end else if (e_hold) begin
         md_rs_v = ra;
         md_rt_v = rb;
      end else if (flush || stall) begin
         model_clear();
      end else begin
         md_valid = d_valid; md_pc = d_pc; md_rs_a = d_rs_addr; md_rt_a = d_rt_addr;
         md_rs_v = d_rs_val; md_rt_v = d_rt_val; md_imm = d_imm; md_bsel = d_bsel;
         md_op = d_aluop;
         md_wa = d_valid ? d_wa : 5'd0;
         md_tnew = (d_tnew == 2'd0) ? 2'd0 : d_tnew - 2'd1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] rt;
      rt = fwd_ref(md_rt_a, md_rt_v);
      chk({tag, ".sa"},    e_sa,            fwd_ref(md_rs_a, md_rs_v));
      chk({tag, ".rtfwd"}, e_rt_fwd,        rt);
      chk({tag, ".sb"},    e_sb,            md_bsel ? md_imm : rt);
      chk({tag, ".aluop"}, {28'd0, e_aluop}, {28'd0, md_op});
      chk({tag, ".pc"},    e_pc,            md_pc);
      chk({tag, ".wa"},    {27'd0, e_wa},   {27'd0, md_wa});
      chk({tag, ".tnew"},  {30'd0, e_tnew}, {30'd0, md_tnew});
      chk({tag, ".valid"}, {31'd0, e_valid}, {31'd0, md_valid});
   endtask

   // One clock edge: advance the model, let the DUT update, sample 1 ns later
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      reset = 1'b1; stall = 1'b0; flush = 1'b0; e_hold = 1'b0;
      d_valid = 1'b0; d_pc = 32'd0; d_rs_addr = 5'd0; d_rt_addr = 5'd0;
      d_rs_val = 32'd0; d_rt_val = 32'd0; d_imm = 32'd0; d_bsel = 1'b0;
      d_aluop = 4'd0; d_wa = 5'd0; d_tnew = 2'd0;
      m_wa = 5'd0; w_wa = 5'd0; m_wd = 32'd0; w_wd = 32'd0; m_ready = 1'b0; w_we = 1'b0;
   endtask

   typedef struct {
      logic [4:0]  rs_a;  logic [31:0] rs_v;
      logic [4:0]  rt_a;  logic [31:0] rt_v;
      logic [31:0] imm;   logic        bsel;
      logic [4:0]  mwa;   logic [31:0] mwd;  logic mrdy;
      logic [4:0]  wwa;   logic [31:0] wwd;  logic wwe;
      logic [31:0] exp_sa; logic [31:0] exp_sb;
   } vec_t;

   vec_t vt[7];

   initial begin
      vt[0] = '{5'd1, 32'd5,    5'd2, 32'd3, 32'd7, 1'b1, 5'd0, 32'd0,    1'b0, 5'd0, 32'd0,    1'b0, 32'd5,    32'd7};
      vt[1] = '{5'd8, 32'd1,    5'd2, 32'd3, 32'd0, 1'b1, 5'd8, 32'h00AA, 1'b1, 5'd8, 32'h00BB, 1'b1, 32'h00AA, 32'd0};
      vt[2] = '{5'd8, 32'd1,    5'd2, 32'd3, 32'd0, 1'b1, 5'd8, 32'h00AA, 1'b0, 5'd8, 32'h00BB, 1'b1, 32'h00BB, 32'd0};
      vt[3] = '{5'd0, 32'h55,   5'd2, 32'd3, 32'd1, 1'b1, 5'd0, 32'h00FF, 1'b1, 5'd0, 32'h00EE, 1'b1, 32'd0,    32'd1};
      vt[4] = '{5'd1, 32'd2,    5'd3, 32'd9, 32'd1, 1'b0, 5'd4, 32'h0011, 1'b1, 5'd3, 32'h0077, 1'b1, 32'd2,    32'h0077};
      vt[5] = '{5'd1, 32'd2,    5'd3, 32'd9, 32'd1, 1'b0, 5'd4, 32'h0011, 1'b1, 5'd3, 32'h0077, 1'b0, 32'd2,    32'd9};
      vt[6] = '{5'd4, 32'd6,    5'd4, 32'd6, 32'd1, 1'b0, 5'd5, 32'd1,    1'b1, 5'd4, 32'h0044, 1'b1, 32'h0044, 32'h0044};

      idle_inputs();
      model_clear();
      reset = 1'b0;
      tick(); tick();
      check_model("reset");
      chk("reset.valid_const", {31'd0, e_valid}, 32'd0);
      chk("reset.pc_const", e_pc, 32'd0);
      reset = 1'b1;

      // Forwarding table: load cleanly, then apply M/W and compare
      for (int i = 0; i < 7; i++) begin
         idle_inputs();
         d_valid = 1'b1; d_pc = 32'h1000 + 32'(i * 4); d_aluop = 4'd0; d_wa = 5'd9;
         d_rs_addr = vt[i].rs_a; d_rs_val = vt[i].rs_v; d_rt_addr = vt[i].rt_a;
         d_rt_val = vt[i].rt_v; d_imm = vt[i].imm; d_bsel = vt[i].bsel;
         tick();
         m_wa = vt[i].mwa; m_wd = vt[i].mwd; m_ready = vt[i].mrdy;
         w_wa = vt[i].wwa; w_wd = vt[i].wwd; w_we = vt[i].wwe;
         #1;
         chk($sformatf("vec%0d.sa", i), e_sa, vt[i].exp_sa);
         chk($sformatf("vec%0d.sb", i), e_sb, vt[i].exp_sb);
         chk($sformatf("vec%0d.valid", i), {31'd0, e_valid}, 32'd1);
         check_model($sformatf("vec%0d", i));
      end

      // Flush, then stall, each turning a real instruction into a bubble
      for (int k = 0; k < 2; k++) begin
         idle_inputs();
         d_valid = 1'b1; d_pc = 32'h2000; d_rs_addr = 5'd7; d_rs_val = 32'd3;
         d_imm = 32'd9; d_bsel = 1'b1; d_aluop = 4'd3; d_wa = 5'd7; d_tnew = 2'd2;
         m_wa = 5'd7; m_wd = 32'h0F0F; m_ready = 1'b1;
         if (k == 0) flush = 1'b1; else stall = 1'b1;
         tick();
         chk($sformatf("bubble%0d.valid", k), {31'd0, e_valid}, 32'd0);
         chk($sformatf("bubble%0d.wa", k),    {27'd0, e_wa},    32'd0);
         chk($sformatf("bubble%0d.aluop", k), {28'd0, e_aluop}, 32'd0);
         chk($sformatf("bubble%0d.tnew", k),  {30'd0, e_tnew},  32'd0);
         chk($sformatf("bubble%0d.sa", k),    e_sa,             32'd0);
         chk($sformatf("bubble%0d.sb", k),    e_sb,             32'd0);
      end

      // Hold for 3 cycles; W provides rt only during the first held cycle
      idle_inputs();
      d_valid = 1'b1; d_pc = 32'h0100; d_rt_addr = 5'd6; d_rt_val = 32'd1;
      d_bsel = 1'b0; d_aluop = 4'd3; d_wa = 5'd2; d_tnew = 2'd1;
      tick();
      e_hold = 1'b1; w_wa = 5'd6; w_wd = 32'h1234; w_we = 1'b1;
      d_pc = 32'h0200; d_aluop = 4'd1; d_valid = 1'b1;
      #1;
      chk("hold0.rtfwd", e_rt_fwd, 32'h1234);
      tick();
      w_we = 1'b0; w_wd = 32'h0; flush = 1'b1;
      #1;
      chk("hold1.rtfwd", e_rt_fwd, 32'h1234);
      chk("hold1.pc",    e_pc,     32'h0100);
      chk("hold1.aluop", {28'd0, e_aluop}, 32'd3);
      tick();
      chk("hold2.rtfwd", e_rt_fwd, 32'h1234);
      chk("hold2.sb",    e_sb,     32'h1234);
      chk("hold2.valid", {31'd0, e_valid}, 32'd1);
      chk("hold2.pc",    e_pc,     32'h0100);
      check_model("hold2");

      // Tnew countdown on load
      idle_inputs();
      d_valid = 1'b1; d_tnew = 2'd2; tick();
      chk("tnew2", {30'd0, e_tnew}, 32'd1);
      d_tnew = 2'd0; tick();
      chk("tnew0", {30'd0, e_tnew}, 32'd0);
      d_tnew = 2'd3; d_valid = 1'b0; d_wa = 5'd12; tick();
      chk("tnew3", {30'd0, e_tnew}, 32'd2);
      chk("invalid.wa", {27'd0, e_wa}, 32'd0);

      // Reset while E is held clears everything
      d_valid = 1'b1; d_pc = 32'h3000; d_aluop = 4'd5; d_wa = 5'd4;
      d_rs_addr = 5'd4; d_rs_val = 32'h77; tick();
      e_hold = 1'b1; reset = 1'b0; tick();
      chk("rsthold.pc",    e_pc, 32'd0);
      chk("rsthold.aluop", {28'd0, e_aluop}, 32'd0);
      chk("rsthold.valid", {31'd0, e_valid}, 32'd0);
      chk("rsthold.sa",    e_sa, 32'd0);
      chk("rsthold.wa",    {27'd0, e_wa}, 32'd0);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         reset   = ($urandom_range(0, 31) != 0);
         e_hold  = ($urandom_range(0, 4) == 0);
         stall   = ($urandom_range(0, 7) == 0);
         flush   = ($urandom_range(0, 7) == 0);
         d_valid = $urandom_range(0, 3) != 0;
         d_pc = $urandom; d_rs_val = $urandom; d_rt_val = $urandom; d_imm = $urandom;
         d_rs_addr = 5'($urandom_range(0, 3)); d_rt_addr = 5'($urandom_range(0, 3));
         d_bsel = 1'($urandom_range(0, 1)); d_aluop = 4'($urandom_range(0, 6));
         d_wa = 5'($urandom_range(0, 31)); d_tnew = 2'($urandom_range(0, 3));
         m_wa = 5'($urandom_range(0, 3)); w_wa = 5'($urandom_range(0, 3));
         m_wd = $urandom; w_wd = $urandom;
         m_ready = 1'($urandom_range(0, 1)); w_we = 1'($urandom_range(0, 1));
         tick();
         check_model($sformatf("rnd%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
